// File: rtl/fmpadding_cfg_pkg.sv
// Shared constants, descriptor layout and validity check for the padding config sequencer.
package fmpadding_cfg_pkg;

  localparam int unsigned XFIELD_W = 8;
  localparam int unsigned YFIELD_W = 8;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PROGRAM = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  // Padding core register byte addresses
  localparam logic [4:0] ADDR_XON  = 5'd0;
  localparam logic [4:0] ADDR_XOFF = 5'd4;
  localparam logic [4:0] ADDR_XEND = 5'd8;
  localparam logic [4:0] ADDR_YON  = 5'd12;
  localparam logic [4:0] ADDR_YOFF = 5'd16;
  localparam logic [4:0] ADDR_YEND = 5'd20;

  // Descriptor payload, XON in the LSBs
  typedef struct packed {
    logic [YFIELD_W-1:0] yend;
    logic [YFIELD_W-1:0] yoff;
    logic [YFIELD_W-1:0] yon;
    logic [XFIELD_W-1:0] xend;
    logic [XFIELD_W-1:0] xoff;
    logic [XFIELD_W-1:0] xon;
  } desc_t;

  // One axis is legal when ON <= OFF <= END+1; 33 bits so END+1 cannot wrap
  function automatic logic axis_ok(input logic [32:0] on, input logic [32:0] off,
                                   input logic [32:0] last);
    return (on <= off) && (off <= last + 33'd1);
  endfunction

endpackage

// File: rtl/fmpadding_desc_fifo.sv
// Depth-2 first-word-fall-through descriptor FIFO.
module fmpadding_desc_fifo #(
  parameter int unsigned W = 48
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         head_valid_o,
  output logic [W-1:0] head_data_o
);

  logic [W-1:0] mem_q [2];
  logic         wptr_q;
  logic         rptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  // A full FIFO still accepts when the head leaves in the same cycle
  assign do_pop       = pop_i && (cnt_q != 2'd0);
  assign do_push      = push_valid_i && ((cnt_q != 2'd2) || do_pop);
  assign push_ready_o = (cnt_q != 2'd2);
  assign head_valid_o = (cnt_q != 2'd0);
  assign head_data_o  = mem_q[rptr_q];

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q  <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fmpadding_cfg_sequencer.sv
// Per-frame sequencer: programs padding geometry, admits one input frame, waits for it to drain.
module fmpadding_cfg_sequencer
  import fmpadding_cfg_pkg::*;
#(
  parameter int unsigned XCOUNTER_BITS = 8,
  parameter int unsigned YCOUNTER_BITS = 8,
  parameter int unsigned FCNT_BITS     = 16
) (
  input  logic                                       ap_clk,
  input  logic                                       ap_rst,
  input  logic                                       desc_valid,
  output logic                                       desc_ready,
  input  logic [3*XCOUNTER_BITS+3*YCOUNTER_BITS-1:0] desc_data,
  input  logic                                       up_tvalid,
  output logic                                       up_tready,
  output logic                                       pad_tvalid,
  input  logic                                       pad_tready,
  input  logic                                       out_tvalid,
  input  logic                                       out_tready,
  output logic                                       we,
  output logic [4:0]                                 wa,
  output logic [31:0]                                wd,
  output logic                                       busy,
  output logic                                       frame_done,
  output logic                                       desc_err,
  output logic [FCNT_BITS-1:0]                       frame_count
);

  localparam int unsigned XW = XCOUNTER_BITS;
  localparam int unsigned YW = YCOUNTER_BITS;
  localparam int unsigned DW = 3*XW + 3*YW;

  // Field i of the X (0=ON,1=OFF,2=END) or Y group of a descriptor vector
  function automatic logic [XW-1:0] fx(input logic [DW-1:0] v, input int unsigned i);
    return v[i*XW +: XW];
  endfunction
  function automatic logic [YW-1:0] fy(input logic [DW-1:0] v, input int unsigned i);
    return v[3*XW + i*YW +: YW];
  endfunction

  logic [DW-1:0]        head_data;
  logic                 head_valid;
  logic                 head_ok;
  logic                 pop;
  logic [DW-1:0]        desc_q, desc_d;
  logic [1:0]           state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [XW-1:0]        ix_q, ix_d, ox_q, ox_d;
  logic [YW-1:0]        iy_q, iy_d, oy_q, oy_d;
  logic                 out_done_q, out_done_d;
  logic [XW-1:0]        in_w;
  logic [YW-1:0]        in_h;
  logic                 nin_zero, gate_c, in_beat, in_last, out_beat, out_last;
  logic                 we_d, busy_d, frame_done_d, desc_err_d;
  logic [4:0]           wa_d;
  logic [31:0]          wd_d;
  logic [FCNT_BITS-1:0] fcnt_d;

  fmpadding_desc_fifo #(.W(DW)) u_fifo (
    .clk_i        (ap_clk),
    .rst_i        (ap_rst),
    .push_valid_i (desc_valid),
    .push_ready_o (desc_ready),
    .push_data_i  (desc_data),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_data_o  (head_data)
  );

  // Head validity and active-frame geometry
  assign head_ok  = axis_ok(33'(fx(head_data, 0)), 33'(fx(head_data, 1)), 33'(fx(head_data, 2)))
                 && axis_ok(33'(fy(head_data, 0)), 33'(fy(head_data, 1)), 33'(fy(head_data, 2)));
  assign in_w     = fx(desc_q, 1) - fx(desc_q, 0);
  assign in_h     = fy(desc_q, 1) - fy(desc_q, 0);
  assign nin_zero = (in_w == '0) || (in_h == '0);

  // Stream gate is combinational so it closes on the very beat that completes the frame
  assign gate_c     = (state_q == ST_RUN) && !nin_zero && !ap_rst;
  assign pad_tvalid = up_tvalid && gate_c;
  assign up_tready  = pad_tready && gate_c;
  assign in_beat    = pad_tvalid && pad_tready;
  assign in_last    = in_beat && (ix_q == in_w - XW'(1)) && (iy_q == in_h - YW'(1));
  assign out_beat   = out_tvalid && out_tready && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign out_last   = out_beat && (ox_q == fx(desc_q, 2)) && (oy_q == fy(desc_q, 2));

  // Next-state, beat counters and registered-output values
  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    idx_d        = idx_q;
    ix_d         = ix_q;
    iy_d         = iy_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    out_done_d   = out_done_q;
    pop          = 1'b0;
    desc_err_d   = 1'b0;
    frame_done_d = 1'b0;
    fcnt_d       = frame_count;

    if (in_beat) begin
      if (ix_q == in_w - XW'(1)) begin
        ix_d = '0;
        iy_d = iy_q + YW'(1);
      end else begin
        ix_d = ix_q + XW'(1);
      end
    end
    if (out_beat) begin
      if (ox_q == fx(desc_q, 2)) begin
        ox_d = '0;
        oy_d = oy_q + YW'(1);
      end else begin
        ox_d = ox_q + XW'(1);
      end
      if (out_last) out_done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (head_valid) begin
          pop = 1'b1;
          if (head_ok) begin
            state_d    = ST_PROGRAM;
            desc_d     = head_data;
            idx_d      = 3'd0;
            ix_d       = '0;
            iy_d       = '0;
            ox_d       = '0;
            oy_d       = '0;
            out_done_d = 1'b0;
          end else begin
            desc_err_d = 1'b1;
          end
        end
      end
      ST_PROGRAM: begin
        if (idx_q == 3'd5) state_d = ST_RUN;
        else               idx_d   = idx_q + 3'd1;
      end
      ST_RUN: begin
        if (nin_zero || in_last) state_d = ST_DRAIN;
      end
      default: begin
        if (out_done_q || out_last) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          fcnt_d       = frame_count + FCNT_BITS'(1);
        end
      end
    endcase

    we_d   = (state_d == ST_PROGRAM);
    busy_d = (state_d != ST_IDLE);
    wa_d   = 5'd0;
    wd_d   = 32'd0;
    if (we_d) begin
      case (idx_d)
        3'd0:    begin wa_d = ADDR_XON;  wd_d = 32'(fx(desc_d, 0)); end
        3'd1:    begin wa_d = ADDR_XOFF; wd_d = 32'(fx(desc_d, 1)); end
        3'd2:    begin wa_d = ADDR_XEND; wd_d = 32'(fx(desc_d, 2)); end
        3'd3:    begin wa_d = ADDR_YON;  wd_d = 32'(fy(desc_d, 0)); end
        3'd4:    begin wa_d = ADDR_YOFF; wd_d = 32'(fy(desc_d, 1)); end
        default: begin wa_d = ADDR_YEND; wd_d = 32'(fy(desc_d, 2)); end
      endcase
    end
  end

  // State and output registers; reset discards any frame in flight
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      desc_q      <= '0;
      idx_q       <= 3'd0;
      ix_q        <= '0;
      iy_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      out_done_q  <= 1'b0;
      we          <= 1'b0;
      wa          <= 5'd0;
      wd          <= 32'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      desc_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      idx_q       <= idx_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      out_done_q  <= out_done_d;
      we          <= we_d;
      wa          <= wa_d;
      wd          <= wd_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      desc_err    <= desc_err_d;
      frame_count <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_fmpadding_cfg_sequencer.sv
// Directed bench for the padding config sequencer.
module tb_fmpadding_cfg_sequencer;
  import fmpadding_cfg_pkg::*;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [47:0] desc_data = '0;
  logic        up_tvalid = 1'b0;
  logic        up_tready;
  logic        pad_tvalid;
  logic        pad_tready = 1'b0;
  logic        out_tvalid = 1'b0;
  logic        out_tready = 1'b0;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        busy;
  logic        frame_done;
  logic        desc_err;
  logic [15:0] frame_count;

  typedef struct { int c; logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int in_beats = 0, out_beats = 0, wr_cnt = 0, open_cycles = 0, first_open = -1;
  int exp_fc = 0;

  fmpadding_cfg_sequencer #(.XCOUNTER_BITS(8), .YCOUNTER_BITS(8), .FCNT_BITS(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_data(desc_data), .up_tvalid(up_tvalid), .up_tready(up_tready),
    .pad_tvalid(pad_tvalid), .pad_tready(pad_tready), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .we(we), .wa(wa), .wd(wd), .busy(busy),
    .frame_done(frame_done), .desc_err(desc_err), .frame_count(frame_count)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // Handshake and write-port monitor, sampled mid-cycle
  always @(negedge ap_clk) begin
    if (pad_tvalid && pad_tready) in_beats++;
    if (out_tvalid && out_tready) out_beats++;
    if (up_tready) begin
      open_cycles++;
      if (first_open < 0) first_open = cyc;
    end
    if (we) begin
      wr_cnt++;
      wr_log.push_back('{c: cyc, a: wa, d: wd});
    end
  end

  function automatic desc_t mk(input int xon, xoff, xend, yon, yoff, yend);
    desc_t d;
    d.xon = 8'(xon); d.xoff = 8'(xoff); d.xend = 8'(xend);
    d.yon = 8'(yon); d.yoff = 8'(yoff); d.yend = 8'(yend);
    return d;
  endfunction

  task automatic step();
    @(posedge ap_clk); #1;
  endtask

  // Offers a descriptor; hs is the cycle number seen in the cycle after the handshake
  task automatic push_desc(input desc_t d, output int hs);
    int n;
    n = 0;
    desc_data = d;
    desc_valid = 1'b1;
    while (!desc_ready && n < 50) begin step(); n++; end
    vectors++;
    if (!desc_ready) begin miscompares++; $display("FAIL push_ready got %0b want 1", desc_ready); end
    step();
    hs = cyc;
    desc_valid = 1'b0;
  endtask

  // Waits out programming, then feeds the input and output sides until frame_done
  task automatic drive_frame(input int nin, input int nout, input bit bp,
                             output int gi, output int go, output bit ok);
    int budget;
    in_beats = 0; out_beats = 0; wr_cnt = 0; open_cycles = 0;
    ok = 1'b0; budget = 0;
    up_tvalid = 1'b1; pad_tready = 1'b1; out_tvalid = 1'b0; out_tready = 1'b0;
    while (!(wr_cnt == 6 && !we) && budget < 100) begin step(); budget++; end
    while (budget < 3000) begin
      if (frame_done) begin ok = 1'b1; break; end
      pad_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_tvalid = (in_beats >= nin) && (out_beats < nout);
      out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget++;
    end
    out_tvalid = 1'b0; out_tready = 1'b0; pad_tready = 1'b1;
    gi = in_beats; go = out_beats;
  endtask

  task automatic test_reset();
    up_tvalid = 1'b1; pad_tready = 1'b1; #1;
    vectors++; if (desc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_desc_ready got %0b want 1", desc_ready); end
    vectors++; if (up_tready !== 1'b0) begin miscompares++; $display("FAIL reset_up_tready got %0b want 0", up_tready); end
    vectors++; if (pad_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_pad_tvalid got %0b want 0", pad_tvalid); end
    vectors++; if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0) begin miscompares++; $display("FAIL reset_wport got we=%0b wa=%0d wd=%0d want 0/0/0", we, wa, wd); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (frame_done !== 1'b0 || desc_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got fd=%0b err=%0b want 0/0", frame_done, desc_err); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
  endtask

  task automatic test_single();
    int hs, gi, go;
    bit ok;
    logic [31:0] exp_wd [6];
    exp_wd = '{32'd1, 32'd5, 32'd5, 32'd1, 32'd5, 32'd5};
    wr_log.delete(); first_open = -1;
    push_desc(mk(1, 5, 5, 1, 5, 5), hs);
    drive_frame(16, 36, 1'b0, gi, go, ok);
    exp_fc++;
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout got no frame_done want frame_done"); end
    vectors++; if (gi !== 16) begin miscompares++; $display("FAIL single_in_beats got %0d want 16", gi); end
    vectors++; if (go !== 36) begin miscompares++; $display("FAIL single_out_beats got %0d want 36", go); end
    vectors++; if (open_cycles !== 16) begin miscompares++; $display("FAIL single_gate_cycles got %0d want 16", open_cycles); end
    vectors++; if (first_open !== hs + 7) begin miscompares++; $display("FAIL single_gate_open got cyc %0d want %0d", first_open, hs + 7); end
    vectors++; if (wr_log.size() !== 6) begin miscompares++; $display("FAIL single_wr_count got %0d want 6", wr_log.size()); end
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      vectors++;
      if (wr_log[i].c !== hs + 1 + i || wr_log[i].a !== 5'(4 * i) || wr_log[i].d !== exp_wd[i]) begin
        miscompares++;
        $display("FAIL single_wr%0d got cyc=%0d wa=%0d wd=%0d want cyc=%0d wa=%0d wd=%0d",
                 i, wr_log[i].c, wr_log[i].a, wr_log[i].d, hs + 1 + i, 4 * i, exp_wd[i]);
      end
    end
    vectors++; if (frame_count !== 16'(exp_fc)) begin miscompares++; $display("FAIL single_frame_count got %0d want %0d", frame_count, exp_fc); end
    step();
    vectors++; if (frame_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_after got fd=%0b busy=%0b want 0/0", frame_done, busy); end
  endtask

  task automatic test_back_to_back();
    int hs, gi, go, fd;
    bit ok;
    logic [31:0] exp_wd [6];
    exp_wd = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd3, 32'd2};
    push_desc(mk(1, 5, 5, 1, 5, 5), hs);
    push_desc(mk(0, 2, 1, 0, 3, 2), hs);
    drive_frame(16, 36, 1'b0, gi, go, ok);
    fd = cyc;
    exp_fc++;
    vectors++; if (!ok || gi !== 16 || go !== 36) begin miscompares++; $display("FAIL b2b_frame1 got ok=%0b in=%0d out=%0d want 1/16/36", ok, gi, go); end
    wr_log.delete();
    drive_frame(6, 6, 1'b0, gi, go, ok);
    exp_fc++;
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout got no frame_done want frame_done"); end
    vectors++; if (gi !== 6 || go !== 6) begin miscompares++; $display("FAIL b2b_frame2 got in=%0d out=%0d want 6/6", gi, go); end
    vectors++; if (wr_log.size() !== 6) begin miscompares++; $display("FAIL b2b_wr_count got %0d want 6", wr_log.size()); end
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      vectors++;
      if (wr_log[i].c !== fd + 1 + i || wr_log[i].a !== 5'(4 * i) || wr_log[i].d !== exp_wd[i]) begin
        miscompares++;
        $display("FAIL b2b_wr%0d got cyc=%0d wa=%0d wd=%0d want cyc=%0d wa=%0d wd=%0d",
                 i, wr_log[i].c, wr_log[i].a, wr_log[i].d, fd + 1 + i, 4 * i, exp_wd[i]);
      end
    end
    vectors++; if (frame_count !== 16'(exp_fc)) begin miscompares++; $display("FAIL b2b_frame_count got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_backpressure();
    int hs, gi, go;
    bit ok;
    push_desc(mk(1, 5, 5, 1, 5, 5), hs);
    drive_frame(16, 36, 1'b1, gi, go, ok);
    exp_fc++;
    vectors++; if (!ok || gi !== 16 || go !== 36) begin miscompares++; $display("FAIL bp_frame got ok=%0b in=%0d out=%0d want 1/16/36", ok, gi, go); end
    vectors++; if (frame_count !== 16'(exp_fc)) begin miscompares++; $display("FAIL bp_frame_count got %0d want %0d", frame_count, exp_fc); end
    in_beats = 0;
    up_tvalid = 1'b1; pad_tready = 1'b1;
    repeat (20) step();
    vectors++; if (in_beats !== 0) begin miscompares++; $display("FAIL bp_leak got %0d beats want 0", in_beats); end
  endtask

  task automatic test_zero_input();
    int hs, gi, go;
    bit ok;
    push_desc(mk(0, 0, 2, 0, 0, 1), hs);
    drive_frame(0, 6, 1'b0, gi, go, ok);
    exp_fc++;
    vectors++; if (!ok || go !== 6) begin miscompares++; $display("FAIL zero_frame got ok=%0b out=%0d want 1/6", ok, go); end
    vectors++; if (open_cycles !== 0 || gi !== 0) begin miscompares++; $display("FAIL zero_gate got open=%0d in=%0d want 0/0", open_cycles, gi); end
    vectors++; if (frame_count !== 16'(exp_fc)) begin miscompares++; $display("FAIL zero_frame_count got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_invalid();
    int hs, gi, go;
    bit ok, busy_seen;
    wr_cnt = 0; busy_seen = 1'b0;
    push_desc(mk(0, 7, 5, 0, 2, 1), hs);
    step();
    vectors++; if (desc_err !== 1'b1) begin miscompares++; $display("FAIL inv_err_pulse got %0b want 1", desc_err); end
    step();
    vectors++; if (desc_err !== 1'b0) begin miscompares++; $display("FAIL inv_err_width got %0b want 0", desc_err); end
    repeat (6) begin busy_seen |= busy; step(); end
    vectors++; if (wr_cnt !== 0 || busy_seen !== 1'b0) begin miscompares++; $display("FAIL inv_idle got writes=%0d busy=%0b want 0/0", wr_cnt, busy_seen); end
    push_desc(mk(0, 2, 1, 0, 2, 1), hs);
    drive_frame(4, 4, 1'b0, gi, go, ok);
    exp_fc++;
    vectors++; if (!ok || gi !== 4 || go !== 4) begin miscompares++; $display("FAIL inv_next got ok=%0b in=%0d out=%0d want 1/4/4", ok, gi, go); end
    vectors++; if (frame_count !== 16'(exp_fc)) begin miscompares++; $display("FAIL inv_frame_count got %0d want %0d", frame_count, exp_fc); end
  endtask

  task automatic test_reset_mid_run();
    int hs, n;
    bit busy_seen;
    push_desc(mk(1, 5, 5, 1, 5, 5), hs);
    push_desc(mk(0, 2, 1, 0, 2, 1), hs);
    in_beats = 0; n = 0;
    up_tvalid = 1'b1; pad_tready = 1'b1;
    while (in_beats < 5 && n < 100) begin step(); n++; end
    vectors++; if (in_beats !== 5) begin miscompares++; $display("FAIL rst_setup got %0d beats want 5", in_beats); end
    ap_rst = 1'b1; #1;
    vectors++; if (up_tready !== 1'b0 || pad_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_gate got ur=%0b pv=%0b want 0/0", up_tready, pad_tvalid); end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0; #1;
    vectors++; if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_outputs got we=%0b wa=%0d wd=%0d busy=%0b want 0/0/0/0", we, wa, wd, busy); end
    vectors++; if (desc_ready !== 1'b1 || frame_done !== 1'b0 || desc_err !== 1'b0) begin miscompares++; $display("FAIL rst_flags got rdy=%0b fd=%0b err=%0b want 1/0/0", desc_ready, frame_done, desc_err); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL rst_frame_count got %0d want 0", frame_count); end
    wr_cnt = 0; busy_seen = 1'b0;
    repeat (12) begin step(); busy_seen |= busy; end
    vectors++; if (wr_cnt !== 0 || busy_seen !== 1'b0 || in_beats !== 5) begin miscompares++; $display("FAIL rst_no_resume got writes=%0d busy=%0b in=%0d want 0/0/5", wr_cnt, busy_seen, in_beats); end
  endtask

  initial begin
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_zero_input();
    test_invalid();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fmpadding_cfg_sequencer.md
Name: fmpadding_cfg_sequencer

Overview:
Per-frame configuration sequencer for the feature-map padding core. Accepts padding descriptors (XON/XOFF/XEND/YON/YOFF/YEND), programs them into the padding core through its we/wa/wd register-write port, then gates the upstream input stream for exactly one frame. It monitors the padding output handshake and reprograms only after the frame has fully drained, so geometry can change per frame without corrupting a frame in flight. Stream data bypasses this block; only valid/ready pass through.

Parameters:
XCOUNTER_BITS, 8, width of X geometry fields (1..32)
YCOUNTER_BITS, 8, width of Y geometry fields (1..32)
FCNT_BITS, 16, width of completed-frame counter

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset; one clock; reset is synchronous and active-high
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor FIFO not full
desc_data  in  3*XCOUNTER_BITS+3*YCOUNTER_BITS  {YEND,YOFF,YON,XEND,XOFF,XON}, XON in LSBs
up_tvalid  in  1  upstream input stream valid
up_tready  out  1  upstream ready (gated)
pad_tvalid  out  1  valid to padding core input (gated)
pad_tready  in  1  padding core input ready
out_tvalid  in  1  padding core output valid (monitor)
out_tready  in  1  padding core output ready (monitor)
we  out  1  register write strobe to padding core
wa  out  5  register byte address
wd  out  32  register write data, zero-extended field
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse per completed frame
desc_err  out  1  one-cycle pulse when an invalid descriptor is dropped
frame_count  out  FCNT_BITS  completed frames, wraps modulo 2^FCNT_BITS

Behaviour:
- Reset: state IDLE, FIFO empty, all counters 0; desc_ready=1, up_tready=0, pad_tvalid=0, we=0, wa=0, wd=0, busy=0, frame_done=0, desc_err=0, frame_count=0.
- Gate: pad_tvalid = up_tvalid & gate; up_tready = pad_tready & gate; gate=1 only in RUN with input frame incomplete. Purely combinational in valid/ready path.
- Descriptor FIFO: depth 2, first-word fall-through; accepts while not full, also when full and dequeueing in the same cycle.
- Validity: XON<=XOFF<=XEND+1 and YON<=YOFF<=YEND+1. Invalid head entry dequeued in IDLE, desc_err pulsed next cycle, state stays IDLE.
- States: IDLE -> PROGRAM (valid head dequeued); PROGRAM: six consecutive cycles, we=1, wa=0,4,8,12,16,20 carrying XON,XOFF,XEND,YON,YOFF,YEND; -> RUN after wa=20. RUN: count input handshakes (pad_tvalid&pad_tready) against NIN=(XOFF-XON)*(YOFF-YON) via x/y counters (no multiplier); on last input beat gate closes the same cycle -> DRAIN. If NIN=0, RUN goes to DRAIN immediately without opening gate. DRAIN: count output handshakes (out_tvalid&out_tready, counted in RUN and DRAIN) against (XEND+1)*(YEND+1) via x/y counters; on last output beat -> IDLE, frame_done=1 and frame_count+1 registered the following cycle.
- Output handshakes outside RUN/DRAIN ignored.
- Latency: desc handshake at cycle 0 into empty FIFO while IDLE -> we cycles 2..7, gate open from cycle 8.
- Back-to-back: last output beat and queued descriptor -> IDLE for one cycle, PROGRAM next.
- Arithmetic: differences in field width; output counters compare against END inclusive; no overflow since counters bounded by END.
- Reset mid-operation: all state discarded including queued descriptors; gate closes in the reset cycle; no partial write sequence resumes.

Decomposition:
- Package fmpadding_cfg_pkg: state enum (IDLE, PROGRAM, RUN, DRAIN), register address constants ADDR_XON..ADDR_YEND (0..20 step 4), descriptor struct typedef parameterised via localparams of field widths, validity function.
- Sub-module fmpadding_desc_fifo: depth-2 FWFT FIFO, synchronous active-high reset.

Test Plan:
- 4x4 frame, pad 1: desc XON=1,XOFF=5,XEND=5,YON=1,YOFF=5,YEND=5 -> writes (0,1),(4,5),(8,5),(12,1),(16,5),(20,5) cycles 2..7; exactly 16 input beats pass, up_tready=0 after 16th; frame_done after 36th output beat; frame_count=1.
- Two descriptors back-to-back (4x4 then 2x3 no pad) -> second PROGRAM starts only after first frame's 36th output beat; second frame passes 6 input beats, expects 6 output beats; frame_count=2.
- Random pad_tready/out_tready backpressure at 50% -> beat counts unchanged, no input beat leaks between frames.
- Zero-input frame XON=XOFF=0,XEND=2,YON=YOFF=0,YEND=1 -> gate never opens, frame_done after 6 output beats.
- Invalid desc XOFF=7,XEND=5 -> desc_err pulse, no we, busy=0; following valid desc proceeds normally.
- ap_rst asserted mid-RUN after 5 input beats with FIFO holding one descriptor -> next cycle all outputs at reset values, FIFO empty, frame_count=0.
